// File: rtl/test_method_sequencer.sv
// Sequential self-test scheduler: walks the enabled method slots one at a time
// through a req/busy/return handshake and records pass, fail and timeout per slot.
module test_method_sequencer #(
  parameter int N_METHODS = 4,
  parameter int IDX_W     = 4,
  parameter int ACK_WAIT  = 4,
  parameter int TIMEOUT   = 10000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_METHODS-1:0] enable_mask,
  output logic [N_METHODS-1:0] test_req,
  input  logic [N_METHODS-1:0] test_busy,
  input  logic [N_METHODS-1:0] test_return,
  output logic                 busy,
  output logic                 done,
  output logic                 all_pass,
  output logic [N_METHODS-1:0] pass_mask,
  output logic [N_METHODS-1:0] fail_mask,
  output logic [N_METHODS-1:0] timeout_mask,
  output logic [IDX_W-1:0]     cur_idx,
  output logic [31:0]          cycles_last
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SCAN      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_ACK  = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_RECORD    = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_METHODS - 1);
  localparam logic [31:0]      ACK_LIM  = 32'(ACK_WAIT);
  localparam logic [31:0]      TMO_LIM  = 32'(TIMEOUT);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_METHODS-1:0]   en_q, en_d;
  logic [N_METHODS-1:0]   pass_q, pass_d;
  logic [N_METHODS-1:0]   fail_q, fail_d;
  logic [N_METHODS-1:0]   tmo_q, tmo_d;
  logic [N_METHODS-1:0]   req_q, req_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            cyc_q, cyc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [N_METHODS-1:0]   onehot_s;
  logic                   sel_en_s;
  logic                   sel_busy_s;
  logic                   sel_ret_s;
  logic                   last_s;
  logic                   advance_s;
  logic [31:0]            cnt_inc_s;

  // Slot selection decode and saturating cycle-counter increment
  always_comb begin
    onehot_s   = N_METHODS'(1) << idx_q;
    sel_en_s   = |(en_q & onehot_s);
    sel_busy_s = |(test_busy & onehot_s);
    sel_ret_s  = |(test_return & onehot_s);
    last_s     = (idx_q == LAST_IDX);
    cnt_inc_s  = (cnt_q < TMO_LIM) ? (cnt_q + 32'd1) : cnt_q;
  end

  // Next-state, mask update and request generation
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    req_d     = '0;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    busy_d    = busy_q;
    done_d    = done_q;
    advance_s = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          en_d    = enable_mask;
          pass_d  = '0;
          fail_d  = '0;
          tmo_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_SCAN;
        end else begin
          state_d = state_q;
        end
      end
      S_SCAN: begin
        if (sel_en_s) begin
          req_d   = onehot_s;
          state_d = S_ISSUE;
        end else begin
          advance_s = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d   = 32'd1;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        cnt_d = cnt_inc_s;
        if (sel_busy_s) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q >= ACK_LIM) begin
          // never acknowledged: treated as a zero-length method
          cnt_d   = 32'd0;
          state_d = S_RECORD;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_inc_s;
        if (!sel_busy_s) begin
          state_d = S_RECORD;
        end else if (cnt_q >= TMO_LIM) begin
          tmo_d     = tmo_q | onehot_s;
          fail_d    = fail_q | onehot_s;
          advance_s = 1'b1;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_RECORD: begin
        if (sel_ret_s) begin
          pass_d = pass_q | onehot_s;
        end else begin
          fail_d = fail_q | onehot_s;
        end
        cyc_d     = cnt_q;
        advance_s = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance_s) begin
      if (last_s) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = S_SCAN;
      end
    end else begin
      advance_s = 1'b0;
    end
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      tmo_q   <= '0;
      req_q   <= '0;
      cnt_q   <= 32'd0;
      cyc_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign test_req     = req_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign all_pass     = done_q & ~(|fail_q);
  assign pass_mask    = pass_q;
  assign fail_mask    = fail_q;
  assign timeout_mask = tmo_q;
  assign cur_idx      = idx_q;
  assign cycles_last  = cyc_q;

endmodule

// File: tb/tb_test_method_sequencer.sv
// Scoreboard bench for test_method_sequencer: per-slot method models, a
// run-level reference model, and monitors for request pulses and run results.
module tb_test_method_sequencer;

  localparam int N        = 4;
  localparam int IDX_W    = 4;
  localparam int ACK_WAIT = 4;
  localparam int TMO      = 200;
  localparam int NEVER    = 1000000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [N-1:0]     enable_mask = '0;
  logic [N-1:0]     test_busy = '0;
  logic [N-1:0]     test_return = '0;
  logic [N-1:0]     test_req;
  logic             busy, done, all_pass;
  logic [N-1:0]     pass_mask, fail_mask, timeout_mask;
  logic [IDX_W-1:0] cur_idx;
  logic [31:0]      cycles_last;

  test_method_sequencer #(
    .N_METHODS(N), .IDX_W(IDX_W), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .enable_mask(enable_mask),
    .test_req(test_req), .test_busy(test_busy), .test_return(test_return),
    .busy(busy), .done(done), .all_pass(all_pass), .pass_mask(pass_mask),
    .fail_mask(fail_mask), .timeout_mask(timeout_mask), .cur_idx(cur_idx),
    .cycles_last(cycles_last)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Method models: busy is high on ticks dly..dly+blen-1 after the req cycle
  int dly[N];
  int blen[N];
  int ph[N];
  initial begin
    logic [N-1:0] seen;
    for (int i = 0; i < N; i++) ph[i] = 0;
    forever begin
      @(negedge clk);
      seen = test_req;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (!reset) ph[i] = 0;
        else if (seen[i]) ph[i] = 1;
        else if (ph[i] != 0 && ph[i] < NEVER) ph[i]++;
        test_busy[i] = (ph[i] != 0) && (ph[i] >= dly[i]) && (ph[i] < dly[i] + blen[i]);
      end
    end
  end

  typedef struct {
    logic [N-1:0] pass;
    logic [N-1:0] fail;
    logic [N-1:0] tmo;
    logic [31:0]  cyc;
    int           gap;
    bit           from_start;
  } exp_t;

  exp_t        exp_q[$];
  int          req_exp_q[$];
  logic [31:0] m_cyc = 32'd0;
  int          start_cyc = 0;
  int          last_req_cyc = 0;
  int          done_cnt = 0;

  // Reference model: outcome of a whole run from slot configurations
  task automatic predict(input logic [N-1:0] en);
    exp_t e;
    int last_j, base, len;
    e.pass = '0; e.fail = '0; e.tmo = '0;
    last_j = -1; base = 0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        req_exp_q.push_back(i);
        last_j = i;
        if (dly[i] > ACK_WAIT || blen[i] < 1) begin
          if (test_return[i]) e.pass[i] = 1'b1; else e.fail[i] = 1'b1;
          m_cyc = 32'd0;
          base  = ACK_WAIT + 2;
        end else if (dly[i] + blen[i] - 1 >= TMO) begin
          e.fail[i] = 1'b1;
          e.tmo[i]  = 1'b1;
          base = TMO + 1;
        end else begin
          if (test_return[i]) e.pass[i] = 1'b1; else e.fail[i] = 1'b1;
          len   = dly[i] + blen[i] + 1;
          m_cyc = 32'((len < TMO) ? len : TMO);
          base  = len + 1;
        end
      end
    end
    e.cyc        = m_cyc;
    e.from_start = (last_j < 0);
    e.gap        = (last_j < 0) ? (N + 1) : (base + N - 1 - last_j);
    exp_q.push_back(e);
  endtask

  // Request monitor: each pulse one-hot, single-cycle, in predicted slot order
  logic [N-1:0] prev_req = '0;
  int           req_slot;
  always @(negedge clk) begin
    if (reset && test_req != '0) begin
      chk("req_single_cycle", 32'(prev_req), 32'd0);
      if (req_exp_q.size() == 0) begin
        chk("req_unexpected", 32'(test_req), 32'd0);
      end else begin
        req_slot = req_exp_q.pop_front();
        chk("req_slot", 32'(test_req), 32'd1 << req_slot);
      end
      last_req_cyc = cyc;
    end
    prev_req = reset ? test_req : '0;
  end

  // Result monitor: compares each completed run against the scoreboard
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset && done && !prev_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pass_mask", 32'(pass_mask), 32'(mon_e.pass));
        chk("fail_mask", 32'(fail_mask), 32'(mon_e.fail));
        chk("timeout_mask", 32'(timeout_mask), 32'(mon_e.tmo));
        chk("all_pass", 32'(all_pass), 32'(mon_e.fail == '0));
        chk("cycles_last", cycles_last, mon_e.cyc);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("done_latency", 32'(cyc - (mon_e.from_start ? start_cyc : last_req_cyc)),
            32'(mon_e.gap));
      end
    end
    prev_done = done;
  end

  task automatic cfg_default();
    for (int i = 0; i < N; i++) begin
      dly[i]  = 1;
      blen[i] = 20;
    end
    test_return = '1;
  endtask

  task automatic run(input logic [N-1:0] en, input bit poke);
    int target;
    predict(en);
    @(posedge clk); #1;
    enable_mask = en;
    start       = 1'b1;
    start_cyc   = cyc;
    @(posedge clk); #1;
    start       = 1'b0;
    enable_mask = N'($urandom);
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_done_clear", 32'(done), 32'd0);
    chk("run_masks_clear", 32'({pass_mask, fail_mask, timeout_mask}), 32'd0);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1; start = 1'b1; enable_mask = ~en;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("start_ignored_busy", 32'(busy), 32'd1);
    end
    target = done_cnt + 1;
    for (int k = 0; k < 3000 && done_cnt < target; k++) @(posedge clk);
    if (done_cnt < target) begin
      chk("run_timeout", 32'(done_cnt), 32'(target));
      exp_q.delete();
      req_exp_q.delete();
    end else begin
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(done), 32'd1);
    end
  endtask

  // Reset while slot 1 is in its ISSUE cycle or deep in WAIT_DONE
  task automatic reset_mid(input bit at_issue);
    cfg_default();
    blen[0] = 3;
    blen[1] = NEVER;
    test_return = 4'b0011;
    predict(4'b0011);
    @(posedge clk); #1;
    enable_mask = 4'b0011; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (test_req[1]) break;
    end
    chk("reset_reach_slot1", 32'(test_req[1]), 32'd1);
    if (!at_issue) repeat (6) @(negedge clk);
    #1; reset = 1'b0; #1;
    chk("rst_req", 32'(test_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cur_idx", 32'(cur_idx), 32'd0);
    if (!at_issue) begin
      chk("rst_masks", 32'({pass_mask, fail_mask, timeout_mask}), 32'd0);
      chk("rst_cycles_last", cycles_last, 32'd0);
    end
    exp_q.delete();
    req_exp_q.delete();
    m_cyc = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_req", 32'(test_req), 32'd0);
  endtask

  initial begin
    int r;
    cfg_default();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({test_req, busy, done, all_pass, pass_mask, fail_mask,
        timeout_mask}), 32'd0);
    chk("reset_cur_idx", 32'(cur_idx), 32'd0);
    chk("reset_cycles_last", cycles_last, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    cfg_default();
    run(4'b1111, 1'b0);

    test_return = 4'b1011;
    blen[3] = NEVER;
    run(4'b1111, 1'b0);

    cfg_default();
    dly[2] = NEVER;
    run(4'b0101, 1'b1);

    cfg_default();
    run(4'b0001, 1'b0);
    run(4'b0000, 1'b0);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 7);
        dly[i] = (r == 0) ? NEVER : $urandom_range(1, ACK_WAIT + 2);
        r = $urandom_range(0, 9);
        blen[i] = (r == 0) ? NEVER : $urandom_range(0, 30);
      end
      test_return = N'($urandom);
      run(N'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/test_method_sequencer.md
Name: test_method_sequencer

Overview:
- Runs up to N_METHODS generated test methods one after another, each with a req/busy/return handshake, and records pass, fail and timeout per method.
- Replaces per-test ad-hoc simulation wrappers with one reusable controller that can also be synthesized as an on-chip self-test scheduler.
- Sits between a top-level start/status interface and the method ports (`<m>_req`, `<m>_busy`, `<m>_return`) of the modules under test.
- Only one method is active at any time.

Parameters:
- N_METHODS, 4: number of method slots (1..16).
- IDX_W, 4: width of cur_idx; must satisfy 2^IDX_W >= N_METHODS.
- ACK_WAIT, 4: cycles after req to wait for busy to rise (>= 1).
- TIMEOUT, 10000: maximum cycles per method, counted from the req cycle (> ACK_WAIT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a run when the block is in IDLE or DONE.
- enable_mask  in  N_METHODS  slots to run; sampled on accepted start.
- test_req  out  N_METHODS  one-hot request pulse to method i.
- test_busy  in  N_METHODS  busy from method i.
- test_return  in  N_METHODS  boolean return of method i; 1 = success.
- busy  out  1  high from the accepted start until DONE is entered.
- done  out  1  high while in DONE.
- all_pass  out  1  valid while done: fail_mask == 0.
- pass_mask  out  N_METHODS  methods that returned 1.
- fail_mask  out  N_METHODS  methods that returned 0 or timed out.
- timeout_mask  out  N_METHODS  methods that hit TIMEOUT.
- cur_idx  out  IDX_W  slot currently being run.
- cycles_last  out  32  cycle count of the last completed method, from req to RECORD.

Behaviour:
- Reset (reset=0, asynchronous), values applied immediately:
  - all outputs 0, state IDLE, internal counters 0, enable latch 0.
  - This also applies mid-run: test_req drops at once and the run is abandoned.
- States: IDLE, SCAN, ISSUE, WAIT_ACK, WAIT_DONE, RECORD, DONE.
- IDLE / DONE:
  - start=1 → latch enable_mask; clear pass, fail and timeout masks; cur_idx=0; busy=1; done=0; go to SCAN.
  - In DONE, done, all_pass and all masks hold until start or reset.
- SCAN (1 cycle):
  - enable[cur_idx]=1 → ISSUE.
  - Otherwise: if cur_idx == N_METHODS-1 → DONE, else cur_idx+1 and stay in SCAN.
  - A disabled slot sets no mask bit.
  - An all-zero enable_mask reaches DONE after N_METHODS SCAN cycles with all_pass=1.
- ISSUE (1 cycle):
  - test_req[cur_idx]=1 for exactly this cycle; all other req bits 0.
  - Cycle counter set to 1; go to WAIT_ACK.
- Cycle counter: increments by 1 every cycle in WAIT_ACK and WAIT_DONE.
- WAIT_ACK:
  - test_busy[cur_idx]=1 → WAIT_DONE.
  - No busy within ACK_WAIT cycles → method deemed complete with zero length; go to RECORD.
- WAIT_DONE:
  - test_busy[cur_idx]=0 → RECORD.
  - Counter reaches TIMEOUT → set timeout_mask[cur_idx] and fail_mask[cur_idx]; go to NEXT handling; return is not sampled.
- RECORD (1 cycle):
  - Sample test_return[cur_idx]: 1 sets pass_mask bit, 0 sets fail_mask bit.
  - cycles_last ← counter.
- NEXT handling, after RECORD or a timeout:
  - If cur_idx == N_METHODS-1 → DONE (busy=0, done=1).
  - Otherwise cur_idx+1 → SCAN.
- Exactly one of pass/fail is set per run slot; timeout implies fail.
- Ignored inputs:
  - start while busy=1.
  - test_busy/test_return of non-current slots.
  - Busy glitches after RECORD.
- Counters and flags:
  - Cycle counter saturates at TIMEOUT.
  - cycles_last is 32-bit and never wraps within a run.
  - all_pass is combinational from fail_mask, qualified by done.

Test Plan:
- Reset and idle: reset=0 mid-WAIT_DONE on slot 1 → test_req=0 immediately; all masks 0, busy=0, done=0; after release, stays IDLE with no start.
- Pass run: N=4, enable=4'b1111, all models busy for 20 cycles then return=1 → each req a single-cycle pulse in order 0..3; pass_mask=4'b1111, fail_mask=0, all_pass=1, cycles_last=22.
- Mixed results: slot 2 returns 0, slot 3 never drops busy, TIMEOUT=200 → pass=4'b0011, fail=4'b1100, timeout=4'b1000, all_pass=0; slot 3 req-to-DONE = 200 cycles + NEXT.
- Skip and no-ack: enable=4'b0101, slot 2 never asserts busy with return=1 → only req[0] and req[2] pulse; slot 2 recorded as pass after ACK_WAIT; pass=4'b0101.
- Start handling: start pulse during a run → ignored. start in DONE with enable=4'b0001 → masks cleared; new run completes with pass=4'b0001. enable=0 → done after 4 SCAN cycles with all_pass=1.
